// File: rtl/ts_ram_arbiter.sv
// Round-robin arbiter and access sequencer for a shared 16x4 RAM with a bidirectional data bus.
// Each access runs IDLE -> SETUP -> ACCESS (STROBE_CYC cycles) -> FINISH -> IDLE.
module ts_ram_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int STROBE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              done_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_read,
    output logic              ram_write,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam int CNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYC - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner;   // 0 = A, 1 = B
    logic              r_last;    // winner of the most recent contention
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;

    logic w_start;
    logic w_pick_b;
    logic w_active;
    logic w_drive;

    always_comb begin
        w_start  = (r_state == S_IDLE) && (req_a || req_b);
        w_pick_b = req_b;
        if (req_a && req_b) begin
            w_pick_b = ~r_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_SETUP;
                        r_owner <= w_pick_b;
                        if (req_a && req_b) begin
                            r_last <= w_pick_b;
                        end
                        r_we    <= w_pick_b ? we_b    : we_a;
                        r_addr  <= w_pick_b ? addr_b  : addr_a;
                        r_wdata <= w_pick_b ? wdata_b : wdata_a;
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                    r_cnt   <= CNT_LOAD;
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state <= S_FINISH;
                        // Read data is captured while the RAM is still driving the bus.
                        if (!r_we) begin
                            if (r_owner) begin
                                r_rdata_b <= ram_data;
                            end else begin
                                r_rdata_a <= ram_data;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so an async reset drops strobes and drive at once.
    assign w_active  = (r_state != S_IDLE);
    assign w_drive   = w_active && r_we;
    assign busy      = w_active;
    assign gnt_a     = w_active && !r_owner;
    assign gnt_b     = w_active && r_owner;
    assign done_a    = (r_state == S_FINISH) && !r_owner;
    assign done_b    = (r_state == S_FINISH) && r_owner;
    assign ram_read  = (r_state == S_ACCESS) && !r_we;
    assign ram_write = (r_state == S_ACCESS) && r_we;
    assign ram_addr  = r_addr;
    assign ram_data  = w_drive ? r_wdata : {DATA_W{1'bz}};
    assign rdata_a   = r_rdata_a;
    assign rdata_b   = r_rdata_b;

endmodule
